i2c_bus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer sharing one `i2c_controller` among up to NUM_REQ local requesters (sensor readers, config writers). Captures the winning requester's address/data/direction, drives the controller's enable/ready handshake, returns read data and a one-cycle completion pulse to the winner, and aborts on a handshake timeout. Sits directly between the requester blocks and the `i2c_controller` instance.

---
 rtl/i2c_bus_arbiter_if.sv | 38 +++
 rtl/i2c_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of requester-side and controller-side signals of the I2C bus arbiter.
//   req/req_addr/req_data/req_rw : per-requester level request and fields
//   gnt/done/err/rd_data         : per-requester grant, completion, abort, read byte
//   busy/state                   : arbiter status (state: IDLE=0 START=1 BUSY=2 DONE=3)
//   ctl_*                        : handshake with the shared i2c_controller
// Modport master is the arbiter's view; slave is the requesters'/controller's view.
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_rw;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic [7:0]           rd_data;
  logic                 busy;
  logic [1:0]           state;
  logic                 ctl_enable;
  logic [6:0]           ctl_addr;
  logic [7:0]           ctl_data_in;
  logic                 ctl_rw;
  logic                 ctl_ready;
  logic [7:0]           ctl_data_out;

  modport master (
    input  req, req_addr, req_data, req_rw, ctl_ready, ctl_data_out,
    output gnt, done, err, rd_data, busy, state,
           ctl_enable, ctl_addr, ctl_data_in, ctl_rw
  );

  modport slave (
    output req, req_addr, req_data, req_rw, ctl_ready, ctl_data_out,
    input  gnt, done, err, rd_data, busy, state,
           ctl_enable, ctl_addr, ctl_data_in, ctl_rw
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one i2c_controller
// among NUM_REQ requesters. Captures the winner's fields at grant, runs the
// controller enable/ready handshake, returns read data and a one-cycle done
// pulse, and aborts with err if START or BUSY lasts TIMEOUT cycles.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : i2c_bus_arbiter_if.master (requester and controller signals)
module i2c_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  i2c_bus_arbiter_if.master  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  logic [1:0]         st;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      sel;
  logic               found;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic               err_r;
  logic               busy_r;
  logic               en_r;
  logic               rw_r;
  logic [6:0]         addr_r;
  logic [7:0]         wdata_r;
  logic [7:0]         rd_r;
  logic [6:0]         addr_arr [NUM_REQ];
  logic [7:0]         data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign addr_arr[g] = bus.req_addr[7*g +: 7];
    assign data_arr[g] = bus.req_data[8*g +: 8];
  end

  // Search upward from ptr with explicit wrap so non-power-of-two counts work.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      cnt     <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      en_r    <= 1'b0;
      rw_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rd_r    <= '0;
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      case (st)
        S_IDLE: begin
          if (found && bus.ctl_ready) begin
            gnt_r   <= NUM_REQ'(1) << sel;
            gidx    <= sel;
            addr_r  <= addr_arr[sel];
            wdata_r <= data_arr[sel];
            rw_r    <= bus.req_rw[sel];
            en_r    <= 1'b1;
            busy_r  <= 1'b1;
            cnt     <= '0;
            st      <= S_START;
          end
        end
        S_START: begin
          if (!bus.ctl_ready) begin
            en_r <= 1'b0;
            cnt  <= '0;
            st   <= S_BUSY;
          end else if (cnt == CNT_MAX) begin
            en_r   <= 1'b0;
            done_r <= gnt_r;
            err_r  <= 1'b1;
            st     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BUSY: begin
          if (bus.ctl_ready) begin
            done_r <= gnt_r;
            if (rw_r) rd_r <= bus.ctl_data_out;
            st <= S_DONE;
          end else if (cnt == CNT_MAX) begin
            done_r <= gnt_r;
            err_r  <= 1'b1;
            st     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          gnt_r  <= '0;
          busy_r <= 1'b0;
          ptr    <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
          st     <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.rd_data     = rd_r;
  assign bus.busy        = busy_r;
  assign bus.state       = st;
  assign bus.ctl_enable  = en_r;
  assign bus.ctl_addr    = addr_r;
  assign bus.ctl_data_in = wdata_r;
  assign bus.ctl_rw      = rw_r;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: a vector table, hand-written
// corner sequences (field stability, reset mid-BUSY, round robin, timeout)
// and randomized transactions checked against a transaction-level model.
module tb_i2c_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int unsigned last_done = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_bus_arbiter_if #(.NUM_REQ(4)) ifa ();
  i2c_bus_arbiter_if #(.NUM_REQ(4)) ift ();

  i2c_bus_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master)
  );
  i2c_bus_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(ift.master)
  );

  typedef struct {
    logic [3:0] rq;
    logic [6:0] ab;
    logic [7:0] db;
    logic [3:0] rwm;
    int         a;
    int         b;
    logic [7:0] resp;
    logic [3:0] eg;
    logic [6:0] ea;
    logic [7:0] ed;
    logic       er;
    logic [7:0] erd;
  } vec_t;

  // Controller model: drops ready after bfm_a+1 cycles of enable, holds it
  // low for bfm_b cycles, then raises it with bfm_resp on data_out.
  int bfm_a = 0;
  int bfm_b = 1;
  logic [7:0] bfm_resp = 8'h00;
  int bph = 0;
  int bcnt = 0;

  initial begin
    ifa.ctl_ready = 1'b1;
    ifa.ctl_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bph = 0; bcnt = 0; ifa.ctl_ready = 1'b1;
      end else if (bph == 0) begin
        if (ifa.ctl_enable) begin
          bcnt++;
          if (bcnt == bfm_a + 1) begin
            ifa.ctl_ready = 1'b0; bph = 1; bcnt = 0;
          end
        end
      end else begin
        bcnt++;
        if (bcnt >= bfm_b) begin
          ifa.ctl_ready = 1'b1; ifa.ctl_data_out = bfm_resp; bph = 0; bcnt = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rq, input logic [6:0] ab, input logic [7:0] db,
                       input logic [3:0] rwm);
    ifa.req = rq;
    ifa.req_rw = rwm;
    for (int i = 0; i < 4; i++) begin
      ifa.req_addr[7*i +: 7] = ab + 7'(i);
      ifa.req_data[8*i +: 8] = db + 8'(i);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " gnt"}, ifa.gnt, 0);
    chk({tag, " done"}, ifa.done, 0);
    chk({tag, " err"}, ifa.err, 0);
    chk({tag, " enable"}, ifa.ctl_enable, 0);
    chk({tag, " rw"}, ifa.ctl_rw, 0);
    chk({tag, " busy"}, ifa.busy, 0);
    chk({tag, " state"}, ifa.state, 0);
    chk({tag, " addr"}, ifa.ctl_addr, 0);
    chk({tag, " wdata"}, ifa.ctl_data_in, 0);
    chk({tag, " rd_data"}, ifa.rd_data, 0);
  endtask

  // One full transaction on the main DUT. 'after' is the req value applied
  // once granted (fields scrambled if requested); 'hold' keeps it past done.
  task automatic txn(input string tag, input vec_t v, input logic [3:0] after,
                     input bit scramble, input bit hold, input bit gap);
    int n, en, gbad;
    bfm_a = v.a; bfm_b = v.b; bfm_resp = v.resp;
    @(negedge clk);
    drive(v.rq, v.ab, v.db, v.rwm);
    n = 0;
    while (ifa.gnt == '0 && n < 20) begin @(negedge clk); n++; end
    chk({tag, " gnt"}, ifa.gnt, v.eg);
    if (gap) chk({tag, " regrant_gap"}, cyc - last_done, 2);
    chk({tag, " addr"}, ifa.ctl_addr, v.ea);
    chk({tag, " wdata"}, ifa.ctl_data_in, v.ed);
    chk({tag, " rw"}, ifa.ctl_rw, v.er);
    chk({tag, " enable"}, ifa.ctl_enable, 1);
    chk({tag, " busy"}, ifa.busy, 1);
    chk({tag, " state_start"}, ifa.state, 1);
    if (scramble) drive(after, ~v.ab, ~v.db, ~v.rwm);
    else ifa.req = after;
    n = 0; en = 0; gbad = 0;
    while (ifa.done == '0 && n < 200) begin
      if (ifa.ctl_enable) en++;
      if (ifa.gnt != v.eg) gbad++;
      @(negedge clk);
      n++;
    end
    if (!hold) ifa.req = '0;
    last_done = cyc;
    chk({tag, " done"}, ifa.done, v.eg);
    chk({tag, " err"}, ifa.err, 0);
    chk({tag, " gnt_at_done"}, ifa.gnt, v.eg);
    chk({tag, " rd_data"}, ifa.rd_data, v.erd);
    chk({tag, " addr_held"}, ifa.ctl_addr, v.ea);
    chk({tag, " wdata_held"}, ifa.ctl_data_in, v.ed);
    chk({tag, " enable_cycles"}, en, v.a + 1);
    chk({tag, " txn_cycles"}, n, v.a + v.b + 1);
    chk({tag, " gnt_unstable"}, gbad, 0);
    chk({tag, " state_done"}, ifa.state, 3);
    @(negedge clk);
    chk({tag, " done_cleared"}, ifa.done, 0);
    chk({tag, " gnt_cleared"}, ifa.gnt, 0);
    chk({tag, " state_idle"}, ifa.state, 0);
    chk({tag, " busy_idle"}, ifa.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    vec_t v;
    int n, en, w, idx, mp;
    logic [7:0] mrd;
    logic [3:0] to_rq [2];
    logic [3:0] to_eg [2];

    // Pointer after reset is 0; each row's expectation follows from the prior winner.
    tbl[0] = '{4'b0100, 7'h1B, 8'hFE, 4'b0000, 3, 20, 8'h77, 4'b0100, 7'h1D, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{4'b0011, 7'h10, 8'h40, 4'b0010, 1, 2,  8'h11, 4'b0001, 7'h10, 8'h40, 1'b0, 8'h00};
    tbl[2] = '{4'b1001, 7'h20, 8'h80, 4'b1000, 0, 1,  8'h3C, 4'b1000, 7'h23, 8'h83, 1'b1, 8'h3C};
    tbl[3] = '{4'b0110, 7'h7E, 8'hF0, 4'b0100, 2, 5,  8'h99, 4'b0010, 7'h7F, 8'hF1, 1'b0, 8'h3C};
    tbl[4] = '{4'b1111, 7'h30, 8'h10, 4'b1011, 4, 3,  8'h5A, 4'b0100, 7'h32, 8'h12, 1'b0, 8'h3C};
    tbl[5] = '{4'b0001, 7'h50, 8'h00, 4'b0001, 1, 4,  8'hA5, 4'b0001, 7'h50, 8'h00, 1'b1, 8'hA5};
    to_rq = '{4'b0100, 4'b1001};
    to_eg = '{4'b0100, 4'b1000};

    rst_n = 1'b0;
    drive(4'b0000, 7'h00, 8'h00, 4'b0000);
    ift.req = '0; ift.req_addr = '0; ift.req_data = '0; ift.req_rw = '0;
    ift.ctl_ready = 1'b1; ift.ctl_data_out = 8'hEE;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset t_gnt", ift.gnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      txn($sformatf("vec%0d", i), tbl[i], 4'b0000, 1'b0, 1'b0, 1'b0);

    // Field stability: requester 1 changes its fields while the transaction runs.
    v = '{4'b0010, 7'h29, 8'h10, 4'b0000, 1, 6, 8'h44, 4'b0010, 7'h2A, 8'h11, 1'b0, 8'hA5};
    txn("fields", v, 4'b0010, 1'b1, 1'b0, 1'b0);

    // Reset during BUSY: everything clears at once, pointer returns to 0.
    bfm_a = 1; bfm_b = 30;
    @(negedge clk);
    drive(4'b0100, 7'h05, 8'h60, 4'b0000);
    n = 0;
    while (ifa.state != 2'd2 && n < 20) begin @(negedge clk); n++; end
    chk("rstmid reached_busy", ifa.state, 2);
    chk("rstmid gnt", ifa.gnt, 4'b0100);
    ifa.req = '0;
    #2 rst_n = 1'b0;
    #1 chk_zero("rstmid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'b1010, 7'h11, 8'h22, 4'b0000, 0, 2, 8'h00, 4'b0010, 7'h12, 8'h23, 1'b0, 8'h00};
    txn("post_rst_ptr", v, 4'b0000, 1'b0, 1'b0, 1'b0);
    v = '{4'b1000, 7'h60, 8'h70, 4'b1000, 2, 3, 8'hC3, 4'b1000, 7'h63, 8'h73, 1'b1, 8'hC3};
    txn("post_rst_r3", v, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Round robin with all requests held: 0,1,2,3,0 and a two-cycle regrant gap.
    for (int i = 0; i < 5; i++) begin
      w = i % 4;
      v = '{4'b1111, 7'h40, 8'h20, 4'b0000, 0, 1, 8'h00,
            4'(1 << w), 7'h40 + 7'(w), 8'h20 + 8'(w), 1'b0, 8'hC3};
      txn($sformatf("rr%0d", i), v, 4'b1111, 1'b0, (i < 4), (i > 0));
    end

    // Randomized transactions against a transaction-level model.
    mp = 1;
    mrd = 8'hC3;
    for (int t = 0; t < 40; t++) begin
      v.rq = 4'($urandom_range(1, 15));
      v.ab = 7'($urandom);
      v.db = 8'($urandom);
      v.rwm = 4'($urandom);
      v.a = $urandom_range(0, 4);
      v.b = $urandom_range(1, 6);
      v.resp = 8'($urandom);
      w = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (mp + k) % 4;
        if (w < 0 && v.rq[idx]) w = idx;
      end
      v.eg = 4'(1 << w);
      v.ea = v.ab + 7'(w);
      v.ed = v.db + 8'(w);
      v.er = v.rwm[w];
      if (v.er) mrd = v.resp;
      v.erd = mrd;
      mp = (w + 1) % 4;
      txn($sformatf("rnd%0d", t), v, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    // Timeout: the controller on dut_t never accepts, so START expires after 16 cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ift.req = to_rq[i];
      n = 0;
      while (ift.gnt == '0 && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("to%0d gnt", i), ift.gnt, to_eg[i]);
      ift.req = '0;
      n = 0; en = 0;
      while (ift.done == '0 && n < 100) begin
        if (ift.ctl_enable) en++;
        @(negedge clk);
        n++;
      end
      chk($sformatf("to%0d enable_cycles", i), en, 16);
      chk($sformatf("to%0d done", i), ift.done, to_eg[i]);
      chk($sformatf("to%0d err", i), ift.err, 1);
      chk($sformatf("to%0d enable_off", i), ift.ctl_enable, 0);
      chk($sformatf("to%0d rd_data", i), ift.rd_data, 0);
      @(negedge clk);
      chk($sformatf("to%0d done_cleared", i), ift.done, 0);
      chk($sformatf("to%0d err_cleared", i), ift.err, 0);
      chk($sformatf("to%0d state_idle", i), ift.state, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
